// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared defaults and the direction encoding for the sync_counter32 slice.
//   CNT_WIDTH_DEFAULT : default counter width in bits
//   CNT_STEP_DEFAULT  : default per-cycle increment/decrement
//   cnt_dir_e         : up_dn encoding (CNT_DOWN = 0, CNT_UP = 1)
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 32;
  localparam int unsigned CNT_STEP_DEFAULT  = 1;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc
//   Combinational next-value logic for the counter: one STEP up or down,
//   carry/borrow detection and the raw terminal-count condition.
//   Build option: COUNTER_SAT_EN defined -> clipped steps saturate at MAX/0
//   instead of wrapping; wrap_nxt still flags every clipped step.
// Ports
//   count    in   WIDTH  current registered count
//   up_dn    in   1      1 = up, 0 = down
//   next     out  WIDTH  value after one enabled step
//   wrap_nxt out  1      step overflowed (carry) or underflowed (borrow)
//   tc_raw   out  1      next step in the current direction would wrap
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = CNT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(CNT_STEP_DEFAULT)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next,
  output logic             wrap_nxt,
  output logic             tc_raw
);

  localparam logic [WIDTH:0]   STEP_X = {1'b0, STEP};
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit on both operands: its value after add/sub is carry/borrow.
  always_comb begin
    sum      = {1'b0, count} + STEP_X;
    diff     = {1'b0, count} - STEP_X;
    next     = count;
    wrap_nxt = 1'b0;
    tc_raw   = 1'b0;
    if (cnt_dir_e'(up_dn) == CNT_UP) begin
      wrap_nxt = sum[WIDTH];
      tc_raw   = (count > (MAX_V - STEP));
`ifdef COUNTER_SAT_EN
      next     = sum[WIDTH] ? MAX_V : sum[WIDTH-1:0];
`else
      next     = sum[WIDTH-1:0];
`endif
    end else begin
      wrap_nxt = diff[WIDTH];
      tc_raw   = (count < STEP);
`ifdef COUNTER_SAT_EN
      next     = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
      next     = diff[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/sync_counter32.sv
// sync_counter32
//   Synchronous up/down counter with enable, synchronous clear and parallel
//   load. Priority on each edge: clr > load > en. Free-runs upward by STEP
//   per clock with en=1, up_dn=1.
//   Build option: COUNTER_SAT_EN defined -> saturating instead of modulo.
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-low reset
//   en       in   1      count enable
//   clr      in   1      synchronous clear to 0
//   load     in   1      synchronous parallel load
//   load_val in   WIDTH  value written on load
//   up_dn    in   1      1 = count up, 0 = count down
//   count    out  WIDTH  registered count
//   tc       out  1      combinational terminal count (en-qualified)
//   wrap     out  1      registered pulse: previous enabled step wrapped/clipped
module sync_counter32
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = CNT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] STEP  = WIDTH'(CNT_STEP_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             tc_raw;

  counter_next_calc #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next_calc (
    .count    (count_q),
    .up_dn    (up_dn),
    .next     (step_next),
    .wrap_nxt (step_wrap),
    .tc_raw   (tc_raw)
  );

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = step_next;
      wrap_d  = step_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = en & tc_raw;

endmodule

// File: tb/tb_sync_counter32.sv
module tb_sync_counter32;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        load;
  logic        up_dn;
  logic [31:0] load_val32;
  logic [7:0]  load_val8;
  logic [31:0] count32;
  logic [7:0]  count8;
  logic        tc32, tc8, wrap32, wrap8;

  sync_counter32 u_dut32 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val32), .up_dn(up_dn),
    .count(count32), .tc(tc32), .wrap(wrap32)
  );

  sync_counter32 #(.WIDTH(8), .STEP(8'd4)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val8), .up_dn(up_dn),
    .count(count8), .tc(tc8), .wrap(wrap8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint c32;
    bit     w32;
    bit     t32;
    longint c8;
    bit     w8;
    bit     t8;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint m32 = 0;
  longint m8  = 0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference: integer arithmetic on the full value range, no bit tricks.
  task automatic predict(input int w, input longint step, input bit r, input bit e,
                         input bit c, input bit l, input bit u, input longint lv,
                         inout longint cnt, output bit wr, output bit tcx);
    longint maxv;
    longint v;
    maxv = (longint'(1) << w) - 1;
    wr   = 1'b0;
    if (!r)      cnt = 0;
    else if (c)  cnt = 0;
    else if (l)  cnt = lv;
    else if (e) begin
      v = u ? cnt + step : cnt - step;
      if (v > maxv) begin
        wr = 1'b1;
`ifdef COUNTER_SAT_EN
        cnt = maxv;
`else
        cnt = v - (maxv + 1);
`endif
      end else if (v < 0) begin
        wr = 1'b1;
`ifdef COUNTER_SAT_EN
        cnt = 0;
`else
        cnt = v + (maxv + 1);
`endif
      end else begin
        cnt = v;
      end
    end
    tcx = e && (u ? (cnt + step > maxv) : (cnt - step < 0));
  endtask

  task automatic drive(input bit r, input bit e, input bit c, input bit l, input bit u,
                       input logic [31:0] v32, input logic [7:0] v8);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; clr = c; load = l; up_dn = u;
    load_val32 = v32; load_val8 = v8;
    predict(32, 1, r, e, c, l, u, longint'(v32), m32, x.w32, x.t32);
    predict(8,  4, r, e, c, l, u, longint'(v8),  m8,  x.w8,  x.t8);
    x.c32 = m32;
    x.c8  = m8;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count32", longint'(count32), x.c32);
        chk("wrap32",  longint'(wrap32),  longint'(x.w32));
        chk("tc32",    longint'(tc32),    longint'(x.t32));
        chk("count8",  longint'(count8),  x.c8);
        chk("wrap8",   longint'(wrap8),   longint'(x.w8));
        chk("tc8",     longint'(tc8),     longint'(x.t8));
      end
    end
  end

  initial begin : stim
    logic [31:0] v32;
    logic [7:0]  v8;
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; up_dn = 1'b1;
    load_val32 = '0; load_val8 = '0;
    #1 rst = 1'b0;

    // reset held with en=1 up, then free-run after release
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);
    for (int i = 0; i < 5; i++)  drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);

    // up wrap at the top (32-bit) and STEP=4 wrap from 0xFC (8-bit)
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 8'hFC);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);

    // down wrap through zero
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 8'h05);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);

    // clr beats load, then hold with en=0
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 8'h34);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0055, 8'h55);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);

    // load with en: load wins
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 8'h10);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);
    // async reset between edges
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);
    #1;
    chk("async_rst_count32", longint'(count32), 0);
    chk("async_rst_count8",  longint'(count8),  0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 8'h0);

    // randomized traffic, biased toward boundary load values
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0: begin v32 = 32'hFFFF_FFFF - 32'($urandom_range(3)); v8 = 8'hFF - 8'($urandom_range(7)); end
        1: begin v32 = 32'($urandom_range(3));                  v8 = 8'($urandom_range(7)); end
        default: begin v32 = $urandom;                          v8 = 8'($urandom); end
      endcase
      drive(($urandom_range(99) >= 2), ($urandom_range(99) < 85),
            ($urandom_range(99) < 4), ($urandom_range(99) < 10),
            1'($urandom_range(1)), v32, v8);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
